// File: rtl/cv32e40p_top.sv
// Minimal RV32 micro-core: clock gates, OBI instruction/data ports, vectored interrupts
// and debug halt/resume. One instruction in flight; the FSM walks FETCH/IWAIT/EXEC(/DREQ/DWAIT).
module cv32e40p_top #(
  parameter int COREV_PULP       = 1,
  parameter int COREV_CLUSTER    = 1,
  parameter int FPU              = 0,
  parameter int ZFINX            = 0,
  parameter int NUM_MHPMCOUNTERS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        pulp_clock_en_i,
  input  logic        scan_cg_en_i,
  output logic        clk_o,
  output logic        clk_pg,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] mtvec_addr_i,
  input  logic [31:0] dm_halt_addr_i,
  input  logic [31:0] hart_id_i,
  input  logic [31:0] dm_exception_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic [31:0] irq_i,
  output logic        irq_ack_o,
  output logic [4:0]  irq_id_o,
  input  logic        debug_req_i,
  output logic        debug_havereset_o,
  output logic        debug_running_o,
  output logic        debug_halted_o,
  input  logic        fetch_enable_i,
  output logic        core_sleep_o
);

  if (FPU != 0) begin : g_fpu_err
    $error("FPU must be 0");
  end
  if (ZFINX != 0) begin : g_zfinx_err
    $error("ZFINX must be 0");
  end
  if (NUM_MHPMCOUNTERS < 0 || NUM_MHPMCOUNTERS > 29) begin : g_hpm_err
    $error("NUM_MHPMCOUNTERS out of range 0..29");
  end
  if (COREV_CLUSTER != 0 && COREV_CLUSTER != 1) begin : g_cluster_err
    $error("COREV_CLUSTER must be 0 or 1");
  end

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_IMM   = 7'b0010011;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] INSN_MRET = 32'h30200073;
  localparam logic [31:0] INSN_DRET = 32'h7B200073;
  localparam logic [31:0] INSN_WFI  = 32'h10500073;

  // Latch-based gates: enables only change while clk_i is low, so no glitches.
  logic cg_en_latch, pg_en_latch, pg_gate;
  always_latch begin
    if (!clk_i) begin
      cg_en_latch = en_i | scan_cg_en_i;
      pg_en_latch = pulp_clock_en_i | scan_cg_en_i;
    end
  end
  assign pg_gate = (COREV_PULP != 0) ? pg_en_latch : 1'b1;
  assign clk_o   = clk_i & cg_en_latch;
  assign clk_pg  = clk_i & cg_en_latch & pg_gate;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_IWAIT, S_EXEC, S_DREQ, S_DWAIT, S_SLEEP
  } state_e;

  state_e      state_q, state_d, exec_next;
  logic [31:0] pc_q, pc_d, next_pc;
  logic [31:0] ir_q;
  logic [31:0] mepc_q, mepc_d, dpc_q, dpc_d;
  logic [31:0] daddr_q, daddr_d, dwdata_q, dwdata_d;
  logic        dwe_q, dwe_d;
  logic        mie_q, mie_d, dbg_mode_q, dbg_mode_d;
  logic        dbg_req_q, havereset_q, irq_ack_q;
  logic [31:0] irq_pend_q, irq_clr;
  logic [4:0]  irq_id_q, irq_sel;
  logic        take_irq, take_dbg;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_u, imm_j, mem_sum;
  logic        is_mem, is_store;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_u   = {ir_q[31:12], 12'd0};
  assign imm_j   = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign is_store = (opcode == OPC_STORE) && (funct3 == 3'b010);
  assign is_mem   = is_store || ((opcode == OPC_LOAD) && (funct3 == 3'b010));
  assign mem_sum  = rs1_val + (is_store ? imm_s : imm_i);

  // Highest-numbered pending line wins.
  always_comb begin
    irq_sel = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (irq_pend_q[i]) irq_sel = 5'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mepc_d     = mepc_q;
    dpc_d      = dpc_q;
    mie_d      = mie_q;
    dbg_mode_d = dbg_mode_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    dwe_d      = dwe_q;
    rf_we      = 1'b0;
    rf_wdata   = 32'd0;
    take_irq   = 1'b0;
    take_dbg   = 1'b0;
    irq_clr    = 32'd0;
    next_pc    = pc_q + 32'd4;
    exec_next  = S_FETCH;
    case (state_q)
      S_IDLE: begin
        if (fetch_enable_i) begin
          state_d = S_FETCH;
          pc_d    = boot_addr_i;
        end
      end
      S_FETCH: if (instr_gnt_i) state_d = S_IWAIT;
      S_IWAIT: if (instr_rvalid_i) state_d = S_EXEC;
      S_EXEC: begin
        if (is_mem) begin
          state_d  = S_DREQ;
          pc_d     = next_pc;
          daddr_d  = {mem_sum[31:2], 2'b00};
          dwdata_d = rs2_val;
          dwe_d    = is_store;
        end else begin
          if (opcode == OPC_LUI) begin
            rf_we    = 1'b1;
            rf_wdata = imm_u;
          end else if (opcode == OPC_IMM && funct3 == 3'b000) begin
            rf_we    = 1'b1;
            rf_wdata = rs1_val + imm_i;
          end else if (opcode == OPC_JAL) begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + 32'd4;
            next_pc  = pc_q + imm_j;
          end else if (ir_q == INSN_MRET) begin
            next_pc = mepc_q;
            mie_d   = 1'b1;
          end else if (ir_q == INSN_DRET) begin
            next_pc    = dpc_q;
            dbg_mode_d = 1'b0;
          end else if (ir_q == INSN_WFI) begin
            exec_next = S_SLEEP;
          end
          // Debug entry outranks interrupts; a trap also cancels a WFI sleep.
          if (dbg_req_q && !dbg_mode_q) begin
            take_dbg   = 1'b1;
            dpc_d      = next_pc;
            pc_d       = dm_halt_addr_i;
            dbg_mode_d = 1'b1;
            state_d    = S_FETCH;
          end else if ((irq_pend_q != 32'd0) && mie_q && !dbg_mode_q) begin
            take_irq = 1'b1;
            irq_clr  = 32'd1 << irq_sel;
            mepc_d   = next_pc;
            pc_d     = mtvec_addr_i + {25'd0, irq_sel, 2'b00};
            mie_d    = 1'b0;
            state_d  = S_FETCH;
          end else begin
            pc_d    = next_pc;
            state_d = exec_next;
          end
        end
      end
      S_DREQ: if (data_gnt_i) state_d = S_DWAIT;
      S_DWAIT: begin
        if (data_rvalid_i) begin
          rf_we    = !dwe_q;
          rf_wdata = data_rdata_i;
          state_d  = S_FETCH;
        end
      end
      S_SLEEP: if ((irq_pend_q != 32'd0) || dbg_req_q) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= 32'd0;
      ir_q        <= 32'd0;
      mepc_q      <= 32'd0;
      dpc_q       <= 32'd0;
      daddr_q     <= 32'd0;
      dwdata_q    <= 32'd0;
      dwe_q       <= 1'b0;
      mie_q       <= 1'b1;
      dbg_mode_q  <= 1'b0;
      dbg_req_q   <= 1'b0;
      havereset_q <= 1'b1;
      irq_ack_q   <= 1'b0;
      irq_id_q    <= 5'd0;
      irq_pend_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mepc_q     <= mepc_d;
      dpc_q      <= dpc_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      dwe_q      <= dwe_d;
      mie_q      <= mie_d;
      dbg_mode_q <= dbg_mode_d;
      dbg_req_q  <= (dbg_req_q | debug_req_i) & ~take_dbg;
      irq_pend_q <= (irq_pend_q | irq_i) & ~irq_clr;
      irq_ack_q  <= take_irq;
      if (take_irq) irq_id_q <= irq_sel;
      if (state_q == S_IWAIT && instr_rvalid_i) ir_q <= instr_rdata_i;
      if (state_q == S_FETCH && instr_gnt_i) havereset_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
  end

  // OBI: req and its address/data are held steady from entry to the granting edge.
  assign instr_req_o  = (state_q == S_FETCH);
  assign instr_addr_o = pc_q;
  assign data_req_o   = (state_q == S_DREQ);
  assign data_we_o    = data_req_o & dwe_q;
  assign data_be_o    = {4{data_req_o}};
  assign data_addr_o  = daddr_q;
  assign data_wdata_o = dwdata_q;

  assign irq_ack_o         = irq_ack_q;
  assign irq_id_o          = irq_id_q;
  assign debug_havereset_o = havereset_q;
  assign debug_halted_o    = dbg_mode_q;
  assign debug_running_o   = (state_q != S_IDLE) && (state_q != S_SLEEP) && !dbg_mode_q;
  assign core_sleep_o      = (state_q == S_IDLE) || (state_q == S_SLEEP);

  logic unused_cfg;
  assign unused_cfg = ^{hart_id_i, dm_exception_addr_i};

endmodule

// File: tb/tb_cv32e40p_top.sv
// Directed bench for cv32e40p_top: OBI responders feed a fixed program; monitors check
// fetch addresses, data requests and interrupt acks against expected queues.
module tb_cv32e40p_top;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, pulp_clock_en_i, scan_cg_en_i;
  logic        clk_o, clk_pg;
  logic [31:0] boot_addr_i, mtvec_addr_i, dm_halt_addr_i, hart_id_i, dm_exception_addr_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [31:0] irq_i;
  logic        irq_ack_o;
  logic [4:0]  irq_id_o;
  logic        debug_req_i, debug_havereset_o, debug_running_o, debug_halted_o;
  logic        fetch_enable_i, core_sleep_o;

  always #5 clk_i = ~clk_i;

  cv32e40p_top dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .pulp_clock_en_i(pulp_clock_en_i),
    .scan_cg_en_i(scan_cg_en_i), .clk_o(clk_o), .clk_pg(clk_pg),
    .boot_addr_i(boot_addr_i), .mtvec_addr_i(mtvec_addr_i), .dm_halt_addr_i(dm_halt_addr_i),
    .hart_id_i(hart_id_i), .dm_exception_addr_i(dm_exception_addr_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .irq_i(irq_i), .irq_ack_o(irq_ack_o), .irq_id_o(irq_id_o),
    .debug_req_i(debug_req_i), .debug_havereset_o(debug_havereset_o),
    .debug_running_o(debug_running_o), .debug_halted_o(debug_halted_o),
    .fetch_enable_i(fetch_enable_i), .core_sleep_o(core_sleep_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int inv_bad  = 0;
  logic started = 1'b0;

  logic [31:0] fetch_q[$];
  logic [68:0] data_q[$];   // {we, be, addr, wdata}
  logic [4:0]  irq_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h80000008: imem = 32'h00002103;  // lw   x2, 0(x0)
      32'h8000000C: imem = 32'h00202223;  // sw   x2, 4(x0)
      32'h0000010C: imem = 32'h30200073;  // mret
      32'h00000200: imem = 32'h12300293;  // addi x5, x0, 0x123
      32'h00000204: imem = 32'h00502423;  // sw   x5, 8(x0)
      32'h00000208: imem = 32'h7B200073;  // dret
      32'h80000018: imem = 32'h12345337;  // lui  x6, 0x12345
      32'h8000001C: imem = 32'h00602623;  // sw   x6, 12(x0)
      32'h80000020: imem = 32'h10500073;  // wfi
      32'h0000011C: imem = 32'h024000EF;  // jal  x1, +0x24
      32'h00000140: imem = 32'h00102823;  // sw   x1, 16(x0)
      32'h00000144: imem = 32'h30200073;  // mret
      default:      imem = 32'h00000013;  // nop
    endcase
  endfunction

  // Instruction responder: grant while credits remain, rvalid the cycle after unless stalled.
  int          icredit = 0;
  logic        istall  = 1'b0;
  logic        ihave   = 1'b0;
  logic [31:0] irsp_addr;
  initial begin
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
      if (!rst_ni) ihave = 1'b0;
      else if (ihave) begin
        if (!istall) begin
          instr_rvalid_i = 1'b1; instr_rdata_i = imem(irsp_addr); ihave = 1'b0;
        end
      end else if (instr_req_o && icredit > 0) begin
        instr_gnt_i = 1'b1; icredit--; ihave = 1'b1; irsp_addr = instr_addr_o;
      end
    end
  end

  logic dhave = 1'b0;
  initial begin
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      if (!rst_ni) dhave = 1'b0;
      else if (dhave) begin
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF; dhave = 1'b0;
      end else if (data_req_o) begin
        data_gnt_i = 1'b1; dhave = 1'b1;
      end
    end
  end

  // Monitor: pops expectations on every accepted request / ack.
  always @(negedge clk_i) begin : monitor
    logic [68:0] de;
    if (rst_ni && instr_req_o && instr_gnt_i) begin
      if (fetch_q.size() == 0) fail_now("fetch_extra", $sformatf("got %08h expected no fetch", instr_addr_o));
      else check("fetch_addr", instr_addr_o, fetch_q.pop_front());
    end
    if (rst_ni && data_req_o && data_gnt_i) begin
      if (data_q.size() == 0) fail_now("data_extra", $sformatf("got %08h expected no data req", data_addr_o));
      else begin
        de = data_q.pop_front();
        check("data_we", {31'd0, data_we_o}, {31'd0, de[68]});
        check("data_be", {28'd0, data_be_o}, {28'd0, de[67:64]});
        check("data_addr", data_addr_o, de[63:32]);
        if (de[68]) check("data_wdata", data_wdata_o, de[31:0]);
      end
    end
    if (rst_ni && irq_ack_o) begin
      if (irq_q.size() == 0) fail_now("irq_ack_extra", $sformatf("got id %0d expected no ack", irq_id_o));
      else check("irq_id", {27'd0, irq_id_o}, {27'd0, irq_q.pop_front()});
    end
    if (started && rst_ni && !core_sleep_o && !(debug_running_o | debug_halted_o)) inv_bad++;
  end

  task automatic wait_fetch(input logic [31:0] a, input string name);
    int k = 0;
    do begin
      @(negedge clk_i); k++;
    end while (!(instr_req_o && instr_gnt_i && instr_addr_o == a) && k < 300);
    if (k >= 300) fail_now(name, $sformatf("timeout, got no fetch expected fetch of %08h", a));
    else check(name, instr_addr_o, a);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; pulp_clock_en_i = 1'b1; scan_cg_en_i = 1'b0;
    boot_addr_i = 32'h80000000; mtvec_addr_i = 32'h100; dm_halt_addr_i = 32'h200;
    hart_id_i = 32'd0; dm_exception_addr_i = 32'h300;
    irq_i = 32'd0; debug_req_i = 1'b0; fetch_enable_i = 1'b0;

    repeat (2) @(negedge clk_i);
    check("rst_instr_req", {31'd0, instr_req_o}, 32'd0);
    check("rst_data_req", {31'd0, data_req_o}, 32'd0);
    check("rst_data_we", {31'd0, data_we_o}, 32'd0);
    check("rst_irq_ack", {31'd0, irq_ack_o}, 32'd0);
    check("rst_instr_addr", instr_addr_o, 32'd0);
    check("rst_data_addr", data_addr_o, 32'd0);
    check("rst_data_wdata", data_wdata_o, 32'd0);
    check("rst_data_be", {28'd0, data_be_o}, 32'd0);
    check("rst_irq_id", {27'd0, irq_id_o}, 32'd0);
    check("rst_havereset", {31'd0, debug_havereset_o}, 32'd1);
    check("rst_running", {31'd0, debug_running_o}, 32'd0);
    check("rst_halted", {31'd0, debug_halted_o}, 32'd0);
    check("rst_sleep", {31'd0, core_sleep_o}, 32'd1);

    // Clock gates sampled in the high phase after enables change in the low phase.
    @(posedge clk_i); #1;
    check("cg_both_on_clk_o", {31'd0, clk_o}, 32'd1);
    check("cg_both_on_clk_pg", {31'd0, clk_pg}, 32'd1);
    @(negedge clk_i); #1; pulp_clock_en_i = 1'b0;
    @(posedge clk_i); #1;
    check("cg_pg_off_clk_o", {31'd0, clk_o}, 32'd1);
    check("cg_pg_off_clk_pg", {31'd0, clk_pg}, 32'd0);
    @(negedge clk_i); #1; en_i = 1'b0; scan_cg_en_i = 1'b1;
    @(posedge clk_i); #1;
    check("cg_scan_clk_o", {31'd0, clk_o}, 32'd1);
    check("cg_scan_clk_pg", {31'd0, clk_pg}, 32'd1);
    @(negedge clk_i); #1; scan_cg_en_i = 1'b0;
    @(posedge clk_i); #1;
    check("cg_off_clk_o", {31'd0, clk_o}, 32'd0);
    check("cg_off_clk_pg", {31'd0, clk_pg}, 32'd0);
    @(negedge clk_i); #1; en_i = 1'b1; pulp_clock_en_i = 1'b1;

    foreach (fetch_q[i]) fetch_q.delete(i);
    fetch_q = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C, 32'h80000010,
                32'h0000010C, 32'h80000014, 32'h00000200, 32'h00000204, 32'h00000208,
                32'h80000018, 32'h8000001C, 32'h80000020, 32'h80000024, 32'h0000011C,
                32'h00000140, 32'h00000144, 32'h80000028};
    data_q.push_back({1'b0, 4'hF, 32'h00000000, 32'h00000000});
    data_q.push_back({1'b1, 4'hF, 32'h00000004, 32'hDEADBEEF});
    data_q.push_back({1'b1, 4'hF, 32'h00000008, 32'h00000123});
    data_q.push_back({1'b1, 4'hF, 32'h0000000C, 32'h12345000});
    data_q.push_back({1'b1, 4'hF, 32'h00000010, 32'h00000120});
    irq_q.push_back(5'd3);
    irq_q.push_back(5'd7);
    icredit = 18;

    @(posedge clk_i); #1; rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_no_req", {31'd0, instr_req_o}, 32'd0);
    check("idle_sleep", {31'd0, core_sleep_o}, 32'd1);

    @(posedge clk_i); #1; fetch_enable_i = 1'b1;
    @(negedge clk_i);
    check("req_before_sample", {31'd0, instr_req_o}, 32'd0);
    @(negedge clk_i);
    check("first_req", {31'd0, instr_req_o}, 32'd1);
    check("first_addr", instr_addr_o, 32'h80000000);
    check("havereset_before_gnt", {31'd0, debug_havereset_o}, 32'd1);
    check("running_after_start", {31'd0, debug_running_o}, 32'd1);
    started = 1'b1;
    @(negedge clk_i);
    check("havereset_after_gnt", {31'd0, debug_havereset_o}, 32'd0);

    // Interrupt raised while the fetch of 0x80000010 is stalled in IWAIT.
    wait_fetch(32'h80000010, "fetch_irq_slot");
    istall = 1'b1;
    @(posedge clk_i); #1; irq_i = 32'h8;
    repeat (2) @(posedge clk_i);
    #1; irq_i = 32'd0;
    @(negedge clk_i);
    check("stalled_no_ack", {31'd0, irq_ack_o}, 32'd0);
    check("stalled_no_req", {31'd0, instr_req_o}, 32'd0);
    istall = 1'b0;
    wait_fetch(32'h0000010C, "irq_vector");
    check("irq_ack_pulse", {31'd0, irq_ack_o}, 32'd1);
    check("irq_ack_id", {27'd0, irq_id_o}, 32'd3);

    wait_fetch(32'h80000014, "mret_return");
    @(posedge clk_i); #1; debug_req_i = 1'b1;
    @(posedge clk_i); #1; debug_req_i = 1'b0;
    wait_fetch(32'h00000200, "debug_entry");
    check("dbg_halted", {31'd0, debug_halted_o}, 32'd1);
    check("dbg_not_running", {31'd0, debug_running_o}, 32'd0);
    wait_fetch(32'h80000018, "dret_resume");
    check("resume_halted", {31'd0, debug_halted_o}, 32'd0);
    check("resume_running", {31'd0, debug_running_o}, 32'd1);

    wait_fetch(32'h80000020, "wfi_fetch");
    for (int k = 0; k < 20 && !core_sleep_o; k++) @(negedge clk_i);
    check("wfi_sleep", {31'd0, core_sleep_o}, 32'd1);
    check("wfi_not_running", {31'd0, debug_running_o}, 32'd0);
    @(posedge clk_i); #1; irq_i = 32'h80;
    @(posedge clk_i); #1; irq_i = 32'd0;
    wait_fetch(32'h80000024, "wake_fetch");
    check("wake_not_sleep", {31'd0, core_sleep_o}, 32'd0);

    for (int k = 0; k < 300 && fetch_q.size() != 0; k++) @(negedge clk_i);
    if (fetch_q.size() != 0) fail_now("fetch_drain", $sformatf("got %0d left expected 0", fetch_q.size()));
    repeat (6) @(negedge clk_i);
    check("data_q_drained", data_q.size(), 32'd0);
    check("irq_q_drained", irq_q.size(), 32'd0);
    check("hold_req", {31'd0, instr_req_o}, 32'd1);
    check("hold_addr", instr_addr_o, 32'h8000002C);

    // Asynchronous reset in the middle of a pending fetch.
    @(posedge clk_i); #3; rst_ni = 1'b0;
    #1;
    check("async_rst_req", {31'd0, instr_req_o}, 32'd0);
    check("async_rst_addr", instr_addr_o, 32'd0);
    check("async_rst_havereset", {31'd0, debug_havereset_o}, 32'd1);
    check("async_rst_sleep", {31'd0, core_sleep_o}, 32'd1);
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b1;
    fetch_q.push_back(32'h80000000);
    icredit = 1;
    wait_fetch(32'h80000000, "reboot_fetch");
    repeat (2) @(negedge clk_i);
    check("reboot_havereset", {31'd0, debug_havereset_o}, 32'd0);
    check("running_or_halted", inv_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_top.md
# cv32e40p_top

Top-level processor block for the cluster: a minimal RV32 micro-core with clock-gate outputs, OBI-style instruction and data ports, vectored interrupt entry and a debug halt/resume mechanism. It sits between the cluster clock/reset infrastructure and the instruction/data interconnect. The core logic itself runs on `clk_i`. `clk_o` and `clk_pg` are gated copies supplied to downstream logic.

## Interface
Parameters:
- `COREV_PULP`, default 1: enables the `pulp_clock_en_i` gate on `clk_pg`; when 0, `clk_pg` equals `clk_o`.
- `COREV_CLUSTER`, default 1: reserved, no functional effect.
- `FPU`, default 0: must be 0; elaboration error otherwise.
- `ZFINX`, default 0: must be 0; elaboration error otherwise.
- `NUM_MHPMCOUNTERS`, default 4: legal range 0..29, no functional effect.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `en_i` in 1: enable for the `clk_o` gate.
- `pulp_clock_en_i` in 1: enable for the `clk_pg` gate.
- `scan_cg_en_i` in 1: forces both gates open.
- `clk_o` out 1: gated clock.
- `clk_pg` out 1: power-domain gated clock.
- `boot_addr_i`, `mtvec_addr_i`, `dm_halt_addr_i`, `hart_id_i`, `dm_exception_addr_i` in 32 each: quasi-static configuration inputs.
- `instr_req_o` out 1, `instr_gnt_i` in 1, `instr_rvalid_i` in 1, `instr_addr_o` out 32, `instr_rdata_i` in 32: instruction OBI port.
- `data_req_o` out 1, `data_gnt_i` in 1, `data_rvalid_i` in 1, `data_we_o` out 1, `data_be_o` out 4, `data_addr_o` out 32, `data_wdata_o` out 32, `data_rdata_i` in 32: data OBI port.
- `irq_i` in 32: interrupt lines.
- `irq_ack_o` out 1: interrupt-taken pulse.
- `irq_id_o` out 5: index of the interrupt being taken.
- `debug_req_i` in 1: debug halt request.
- `debug_havereset_o`, `debug_running_o`, `debug_halted_o` out 1 each: debug status.
- `fetch_enable_i` in 1: starts fetching after reset.
- `core_sleep_o` out 1: core is sleeping.

## Operation
- Clock gates:
  - `clk_o` = `clk_i` AND a latch of (`en_i` | `scan_cg_en_i`), transparent while `clk_i` is low.
  - `clk_pg` is built the same way from (`pulp_clock_en_i` | `scan_cg_en_i`), ANDed with the `clk_o` enable.
- State machine:
  - States: IDLE, FETCH, IWAIT, EXEC, DREQ, DWAIT, SLEEP.
  - After reset the core is in IDLE. It goes to FETCH with PC = `boot_addr_i` on the first cycle `fetch_enable_i` = 1. This happens once; later deassertion is ignored.
- FETCH: drive `instr_req_o`=1, `instr_addr_o`=PC. Hold both until `instr_gnt_i`, then go to IWAIT.
- IWAIT: on `instr_rvalid_i`, capture `instr_rdata_i` and go to EXEC.
- EXEC: execute the subset below, with x0 hardwired to 0 and a 32x32 register file:
  - LUI.
  - ADDI (opcode 0010011, funct3 000; 0x00000013 is NOP).
  - JAL.
  - LW (funct3 010): go to DREQ.
  - SW (funct3 010): go to DREQ.
  - MRET 0x30200073: PC = MEPC, interrupts re-enabled.
  - DRET 0x7B200073: PC = DPC, leave debug mode.
  - WFI 0x10500073: PC+4, then SLEEP.
  - Every other encoding is a NOP with PC+4.
- DREQ: drive `data_req_o`=1, `data_addr_o`={rs1+imm[31:2],2'b00}, `data_be_o`=4'b1111, `data_we_o`=1 for SW / 0 for LW, `data_wdata_o`=rs2. Hold until `data_gnt_i`, then go to DWAIT.
- DWAIT: on `data_rvalid_i`, LW writes `data_rdata_i` to rd; then go to FETCH.
- Interrupts:
  - Any `irq_i` bit high on a clock edge sets a sticky pending bit.
  - At EXEC completion, if pending≠0, interrupts are enabled and the core is not in debug mode, the interrupt is taken:
    - The highest-numbered pending index is selected.
    - MEPC = next PC; PC = `mtvec_addr_i` + 4·id.
    - `irq_ack_o`=1 for one cycle with `irq_id_o`=id; that pending bit is cleared.
    - Interrupts are disabled until MRET.
- Debug:
  - `debug_req_i` sets a sticky request.
  - At EXEC completion it takes priority over an interrupt: DPC = next PC, PC = `dm_halt_addr_i`, enter debug mode. Interrupts are masked while in debug mode.
  - `debug_halted_o` = debug mode. `debug_running_o` = NOT IDLE AND NOT debug mode AND NOT SLEEP.
  - `debug_havereset_o`=1 from reset until the first `instr_gnt_i`.
- SLEEP: `core_sleep_o`=1. Any pending interrupt or debug request returns the core to FETCH; the interrupt or debug entry is then taken at the next EXEC completion. `core_sleep_o` is also 1 in IDLE.
- `hart_id_i` and `dm_exception_addr_i` are unused.

## Timing
- Reset values:
  - `instr_req_o`/`data_req_o`/`data_we_o`/`irq_ack_o` = 0.
  - Addresses and `data_wdata_o` = 0; `data_be_o` = 0; `irq_id_o` = 0.
  - `debug_havereset_o` = 1, `debug_running_o` = 0, `debug_halted_o` = 0, `core_sleep_o` = 1.
- Reset asserted mid-transfer drops all requests asynchronously. Outstanding responses are then ignored.
- At most one outstanding transaction per port.
- `rvalid` is accepted only in IWAIT/DWAIT. `rvalid` arriving in the same cycle as `gnt` is ignored.
- Minimum latency:
  - 3 cycles per non-memory instruction (FETCH→IWAIT→EXEC).
  - 5 cycles per LW/SW.
- Request to the first fetch: `instr_req_o` rises in the cycle after `fetch_enable_i` is sampled high.
- Simultaneous debug request and interrupt: debug is taken first; the interrupt stays pending.

## Test plan
- Reset, then `fetch_enable_i`=1 with `boot_addr_i`=0x80000000 → `instr_req_o`=1 with `instr_addr_o`=0x80000000 in the next cycle; `debug_havereset_o` clears after the gnt; `debug_running_o`=1.
- Stream of NOPs (0x00000013) with gnt, then rvalid one cycle later → fetch addresses 0x80000000, 0x80000004, 0x80000008; no `data_req_o`.
- LW x2,0(x0) returning 0xDEADBEEF, then SW x2,4(x0) → write with `data_addr_o`=0x4, `data_we_o`=1, `data_be_o`=4'hF, `data_wdata_o`=0xDEADBEEF.
- `irq_i`[3] pulsed for 2 cycles while the core is stalled in IWAIT → after the next EXEC: `irq_ack_o` pulses with `irq_id_o`=3 and the next fetch address is 0x0000010C (`mtvec_addr_i`=0x100).
- `debug_req_i` pulsed for 1 cycle → `debug_halted_o`=1, `debug_running_o`=0, next fetch at 0x00000200; a later DRET resumes at DPC with `debug_running_o`=1. `debug_running_o` | `debug_halted_o` is 1 at all times after fetch start.
- Reset asserted while `instr_req_o`=1 → request drops immediately; the core re-boots from `boot_addr_i`.
